multi_mode_counter_gen: RTL and testbench
=========================================

Name: multi_mode_counter_gen

Overview:
Parametrised successor to the team's multi-mode counter game block. It is an up/down counter with configurable width and step, plus selectable wrap or saturate arithmetic. Two score counters track arrivals at the max and min boundaries. A sticky game-over state freezes the block until an explicit restart. It sits as a standalone peripheral driven by switch/control inputs, with flags and scores exposed for display.

Parameters:
WIDTH, 5, bit width of the main counter; MAX = 2^WIDTH-1
STEP_WIDTH, 3, width of the programmable step input
SCORE_WIDTH, 4, width of each score counter
SCORE_MAX, 2^SCORE_WIDTH-1, score value that ends the game (1..2^SCORE_WIDTH-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  count enable
mode  in  2  bit1: 0=up, 1=down; bit0: 0=step of 1, 1=step of step input
step  in  STEP_WIDTH  programmable step magnitude
sat  in  1  0=wrap modulo 2^WIDTH, 1=clamp at 0/MAX
init  in  1  load request
init_value  in  WIDTH  value to load
restart  in  1  leave game-over state
count  out  WIDTH  registered counter value
winner  out  1  combinational, count==MAX
loser  out  1  combinational, count==0
win_score  out  SCORE_WIDTH  registered MAX-arrival count
lose_score  out  SCORE_WIDTH  registered 0-arrival count
gameover  out  1  high in state OVER
who  out  2  00 = no result, 10 = winner side won, 01 = loser side won; registered with the state change

Behaviour:
- Reset is synchronous and active-high, sampled at the clk rising edge. It overrides everything.
- Reset values: state IDLE, count 0, win_score 0, lose_score 0, gameover 0, who 00. As a result winner=0 and loser=1.
- FSM states: IDLE, RUN, OVER.
- Priority per edge: rst > restart (OVER only) > init (IDLE/RUN only) > counting (RUN only).
- IDLE:
  - init=1: count<=init_value; stay IDLE.
  - Else en=1: go to RUN; count unchanged this edge. First count update is on the next edge, so latency en->first change is 2 edges from IDLE.
  - Else hold.
- RUN:
  - init=1: count<=init_value; no score change; stay RUN.
  - Else en=1: count<=nxt as computed below, with scoring.
  - Else en=0: hold everything; stay RUN.
- Arithmetic:
  - s = 1 if mode[0]=0, else step.
  - Up: sum = count+s, computed at WIDTH+1 bits.
  - Down: diff = count-s, computed at WIDTH+1 bits, signed.
  - Wrap (sat=0): nxt = result mod 2^WIDTH.
  - Saturate (sat=1): nxt = min(sum, MAX) going up; max(diff, 0) going down.
  - s=0 gives nxt=count.
- Scoring is arrival-only and uses a registered update on the same edge as count:
  - If nxt==MAX and nxt!=count: win_score+1.
  - Else if nxt==0 and nxt!=count: lose_score+1.
  - Holding at a boundary (saturation, s=0, en=0) does not score.
  - Loads never score.
  - Only one score can change per edge.
- End of game: on the edge where win_score or lose_score becomes SCORE_MAX, state<=OVER, gameover<=1, who<=10 (win) or 01 (lose).
- OVER:
  - count and scores are frozen; en and init are ignored.
  - restart=1: state<=IDLE, count<=0, scores<=0, gameover<=0, who<=00.
- restart outside OVER is ignored.
- Reset in any state, including mid-RUN or OVER, produces the reset values on the next edge.
- Scores never exceed SCORE_MAX and never wrap.

Test Plan:
1. Reset: rst=1 for 2 edges with en=1 and init=1 -> count=0, scores=0, gameover=0, who=00, loser=1, winner=0; after release with en=1, count stays 0 for 1 edge and becomes 1 on the 2nd edge (mode=00).
2. Wrap up by 1: load 30, en=1, mode=00, sat=0 -> count 31 (winner=1, win_score=1), then 0 (lose_score=1), then 1.
3. Saturate up by step: load 29, mode=01, step=3, sat=1 -> count 31 (win_score+1), then 31 held for 5 edges with no further score.
4. Down wrap by step: load 1, mode=11, step=2, sat=0 -> count 31 (win_score+1), then 29. Next, load 2 with mode=10, sat=1 -> count 1, then 0 (lose_score+1), then held at 0 with no further score.
5. Game over: from reset, en=1, mode=00, sat=0 for 15 full wraps -> win_score reaches 15 on the 15th arrival at 31; gameover=1, who=10; lose_score=14 (the 15th arrival at 0 never occurs); count frozen at 31. init=1 with init_value=5 is ignored. restart=1 -> IDLE, count=0, scores=0, who=00.
6. Load during RUN: mid-count, init=1 with init_value=31 -> count=31, winner=1, scores unchanged. init and en asserted together -> load wins, no increment.

Source files
------------

// File: rtl/multi_mode_counter_gen.sv
// Up/down counter game block: wrap or saturate arithmetic, boundary-arrival scoring,
// and a sticky game-over state that only an explicit restart clears.
module multi_mode_counter_gen #(
    parameter int WIDTH       = 5,
    parameter int STEP_WIDTH  = 3,
    parameter int SCORE_WIDTH = 4,
    parameter int SCORE_MAX   = (1 << SCORE_WIDTH) - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [STEP_WIDTH-1:0]  step,
    input  logic                   sat,
    input  logic                   init,
    input  logic [WIDTH-1:0]       init_value,
    input  logic                   restart,
    output logic [WIDTH-1:0]       count,
    output logic                   winner,
    output logic                   loser,
    output logic [SCORE_WIDTH-1:0] win_score,
    output logic [SCORE_WIDTH-1:0] lose_score,
    output logic                   gameover,
    output logic [1:0]             who
);

    // Internal width leaves headroom so saturation is correct even if the step is wider than the count.
    localparam int CW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 2;
    localparam logic [WIDTH-1:0]       MAX  = '1;
    localparam logic [SCORE_WIDTH-1:0] SMAX = SCORE_WIDTH'(SCORE_MAX);
    localparam logic [SCORE_WIDTH-1:0] ONE  = SCORE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [SCORE_WIDTH-1:0] win_q, win_d, lose_q, lose_d;
    logic                   go_q, go_d;
    logic [1:0]             who_q, who_d;
    logic [STEP_WIDTH-1:0]  step_sel;
    logic [WIDTH-1:0]       nxt;

    function automatic logic [WIDTH-1:0] next_count(
        input logic [WIDTH-1:0]      cnt,
        input logic [STEP_WIDTH-1:0] s,
        input logic                  down,
        input logic                  clamp
    );
        logic [CW-1:0]        c_ext;
        logic [CW-1:0]        s_ext;
        logic [CW-1:0]        sum;
        logic signed [CW-1:0] diff;
        c_ext = CW'(cnt);
        s_ext = CW'(s);
        sum   = c_ext + s_ext;
        diff  = signed'(c_ext) - signed'(s_ext);
        if (!down)
            return (clamp && (sum > CW'(MAX))) ? MAX : sum[WIDTH-1:0];
        return (clamp && (diff < 0)) ? '0 : diff[WIDTH-1:0];
    endfunction

    assign step_sel = mode[0] ? step : STEP_WIDTH'(1);
    assign nxt      = next_count(count_q, step_sel, mode[1], sat);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        win_d   = win_q;
        lose_d  = lose_q;
        go_d    = go_q;
        who_d   = who_q;
        case (state_q)
            IDLE: begin
                if (init)
                    count_d = init_value;
                else if (en)
                    state_d = RUN;
            end
            RUN: begin
                if (init) begin
                    count_d = init_value;
                end else if (en) begin
                    count_d = nxt;
                    // Only a change onto a boundary scores; holding there never does.
                    if ((nxt == MAX) && (nxt != count_q)) begin
                        win_d = win_q + ONE;
                        if (win_d == SMAX) begin
                            state_d = OVER;
                            go_d    = 1'b1;
                            who_d   = 2'b10;
                        end
                    end else if ((nxt == '0) && (nxt != count_q)) begin
                        lose_d = lose_q + ONE;
                        if (lose_d == SMAX) begin
                            state_d = OVER;
                            go_d    = 1'b1;
                            who_d   = 2'b01;
                        end
                    end
                end
            end
            OVER: begin
                if (restart) begin
                    state_d = IDLE;
                    count_d = '0;
                    win_d   = '0;
                    lose_d  = '0;
                    go_d    = 1'b0;
                    who_d   = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            win_q   <= '0;
            lose_q  <= '0;
            go_q    <= 1'b0;
            who_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            go_q    <= go_d;
            who_q   <= who_d;
        end
    end

    assign count      = count_q;
    assign winner     = (count_q == MAX);
    assign loser      = (count_q == '0);
    assign win_score  = win_q;
    assign lose_score = lose_q;
    assign gameover   = go_q;
    assign who        = who_q;

endmodule

// File: tb/tb_multi_mode_counter_gen.sv
// Directed-vector bench: the driver queues the expected post-edge state, a monitor pops and compares.
module tb_multi_mode_counter_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, sat = 1'b0, init = 1'b0, restart = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] step = 3'd0;
    logic [4:0] init_value = 5'd0;
    logic [4:0] count;
    logic       winner, loser, gameover;
    logic [3:0] win_score, lose_score;
    logic [1:0] who;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       ck;
        logic [4:0] c;
        logic [3:0] w;
        logic [3:0] l;
        logic       g;
        logic [1:0] wh;
    } exp_t;
    exp_t sb[$];

    multi_mode_counter_gen #(
        .WIDTH(5), .STEP_WIDTH(3), .SCORE_WIDTH(4), .SCORE_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step), .sat(sat),
        .init(init), .init_value(init_value), .restart(restart),
        .count(count), .winner(winner), .loser(loser),
        .win_score(win_score), .lose_score(lose_score),
        .gameover(gameover), .who(who)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's inputs and queue the state expected right after that edge.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic [2:0] st,
                       input logic sa, input logic i, input logic [4:0] iv, input logic rs,
                       input logic ck, input logic [4:0] c, input logic [3:0] w,
                       input logic [3:0] l, input logic g, input logic [1:0] wh);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; step = st; sat = sa;
        init = i; init_value = iv; restart = rs;
        x.ck = ck; x.c = c; x.w = w; x.l = l; x.g = g; x.wh = wh;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                if (x.ck) begin
                    check("count", int'(count), int'(x.c));
                    check("winner", int'(winner), int'(x.c == 5'd31));
                    check("loser", int'(loser), int'(x.c == 5'd0));
                    check("win_score", int'(win_score), int'(x.w));
                    check("lose_score", int'(lose_score), int'(x.l));
                    check("gameover", int'(gameover), int'(x.g));
                    check("who", int'(who), int'(x.wh));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        //   rst en mode step sat init iv rst_g | ck count win lose go who
        // 1. Reset overrides en and init; then 2-edge start latency.
        cyc(1, 1, 2'b00, 0, 0, 1, 7, 0, 1, 0, 0, 0, 0, 2'b00);
        cyc(1, 1, 2'b00, 0, 0, 1, 7, 0, 1, 0, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2'b00);
        // 2. Wrap up by 1 from 30.
        cyc(0, 1, 2'b00, 0, 0, 1, 30, 0, 1, 30, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 31, 1, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00);
        // 3. Saturate up by step 3 from 29; holding at MAX does not score.
        cyc(0, 1, 2'b01, 3, 1, 1, 29, 0, 1, 29, 1, 1, 0, 2'b00);
        cyc(0, 1, 2'b01, 3, 1, 0, 0, 0, 1, 31, 2, 1, 0, 2'b00);
        for (int k = 0; k < 5; k++)
            cyc(0, 1, 2'b01, 3, 1, 0, 0, 0, 1, 31, 2, 1, 0, 2'b00);
        // 4. Down wrap by 2 from 1, then saturate down by 1 from 2.
        cyc(0, 1, 2'b11, 2, 0, 1, 1, 0, 1, 1, 2, 1, 0, 2'b00);
        cyc(0, 1, 2'b11, 2, 0, 0, 0, 0, 1, 31, 3, 1, 0, 2'b00);
        cyc(0, 1, 2'b11, 2, 0, 0, 0, 0, 1, 29, 3, 1, 0, 2'b00);
        cyc(0, 1, 2'b10, 0, 1, 1, 2, 0, 1, 2, 3, 1, 0, 2'b00);
        cyc(0, 1, 2'b10, 0, 1, 0, 0, 0, 1, 1, 3, 1, 0, 2'b00);
        cyc(0, 1, 2'b10, 0, 1, 0, 0, 0, 1, 0, 3, 2, 0, 2'b00);
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 2'b10, 0, 1, 0, 0, 0, 1, 0, 3, 2, 0, 2'b00);
        // Step of zero holds, en=0 holds, restart outside OVER ignored.
        cyc(0, 1, 2'b01, 0, 0, 0, 0, 0, 1, 0, 3, 2, 0, 2'b00);
        cyc(0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 3, 2, 0, 2'b00);
        // 6. Load during RUN never scores; load beats increment.
        cyc(0, 0, 2'b00, 0, 0, 1, 31, 0, 1, 31, 3, 2, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 1, 10, 0, 1, 10, 3, 2, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 1, 1, 11, 3, 2, 0, 2'b00);
        // 5. Fifteen wraps from reset end the game on the winner side.
        cyc(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        for (int k = 1; k <= 15; k++) begin
            for (int v = 1; v <= 31; v++)
                cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 5'(v), (v == 31) ? 4'(k) : 4'(k - 1), 4'(k - 1),
                    (k == 15 && v == 31), (k == 15 && v == 31) ? 2'b10 : 2'b00);
            if (k < 15)
                cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4'(k), 4'(k), 0, 2'b00);
        end
        cyc(0, 1, 2'b00, 0, 0, 1, 5, 0, 1, 31, 15, 14, 1, 2'b10);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 31, 15, 14, 1, 2'b10);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00);
        cyc(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00);
        // Loser-side game over: load 1 then step down to 0, fifteen times.
        for (int k = 1; k <= 15; k++) begin
            cyc(0, 0, 2'b10, 0, 0, 1, 1, 0, 1, 1, 0, 4'(k - 1), 0, 2'b00);
            cyc(0, 1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 4'(k), (k == 15), (k == 15) ? 2'b01 : 2'b00);
        end
        cyc(0, 1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 15, 1, 2'b01);
        // Reset out of OVER.
        cyc(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
